// File: rtl/lcd_char_writer_pkg.sv
// Shared definitions for the HD44780 character writer: default timings,
// FSM encodings, power-on nibble/byte tables and command codes.
package lcd_char_writer_pkg;

  // Default timings in 50 MHz clock cycles
  localparam int T_POWERUP_DEF = 750000;
  localparam int T_4100US_DEF  = 205000;
  localparam int T_100US_DEF   = 5000;
  localparam int T_40US_DEF    = 2000;
  localparam int T_1640US_DEF  = 82000;
  localparam int T_1US_DEF     = 50;
  localparam int T_SETUP_DEF   = 2;
  localparam int T_EPULSE_DEF  = 12;
  localparam int T_HOLD_DEF    = 1;
  localparam int CNT_W_DEF     = 20;

  // HD44780 command codes
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h28;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;

  // Writer FSM; the configuration bytes of the init sequence reuse the
  // WR_HI / WR_GAP / WR_LO / WAIT path while init_done is still 0.
  typedef enum logic [2:0] {
    ST_PWR_WAIT  = 3'd0,
    ST_INIT_NIB  = 3'd1,
    ST_INIT_WAIT = 3'd2,
    ST_IDLE      = 3'd3,
    ST_WR_HI     = 3'd4,
    ST_WR_GAP    = 3'd5,
    ST_WR_LO     = 3'd6,
    ST_WAIT      = 3'd7
  } wr_state_t;

  // Nibble strobe sequencer
  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_SETUP = 2'd1,
    SB_EHIGH = 2'd2,
    SB_HOLD  = 2'd3
  } strobe_state_t;

  // 4-bit interface wake-up nibbles, sent one at a time
  function automatic logic [3:0] init_nibble(input logic [1:0] k);
    logic [3:0] n;
    case (k)
      2'd0:    n = 4'h3;
      2'd1:    n = 4'h3;
      2'd2:    n = 4'h3;
      2'd3:    n = 4'h2;
      default: n = 4'h3;
    endcase
    return n;
  endfunction

  // Full configuration bytes written after the wake-up nibbles
  function automatic logic [7:0] cfg_byte(input logic [1:0] j);
    logic [7:0] b;
    case (j)
      2'd0:    b = CMD_FUNC_SET;
      2'd1:    b = CMD_ENTRY;
      2'd2:    b = CMD_DISP_ON;
      2'd3:    b = CMD_CLEAR;
      default: b = CMD_CLEAR;
    endcase
    return b;
  endfunction

  // Clear and home commands need the long 1.64 ms execution wait
  function automatic logic needs_long_wait(input logic is_cmd, input logic [7:0] b);
    return is_cmd && ((b == CMD_CLEAR) || (b == CMD_HOME) || (b == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Drives one 4-bit transfer onto the LCD pins: SETUP (data valid, E low),
// EHIGH (E high), HOLD (E low, data held), then a one-cycle done pulse.
// Outside a transfer lcd_e, lcd_rs and lcd_d are all 0.
module lcd_nibble_strobe
  import lcd_char_writer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_EPULSE = T_EPULSE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_d,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 32'd1);
  localparam logic [CNT_W-1:0] LD_EPULSE = CNT_W'(T_EPULSE - 32'd1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 32'd1);

  strobe_state_t    state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             rs_next;
  logic [3:0]       d_next;
  logic             done_next;

  // Next-state, counter reload and next pin values for the strobe phases
  always_comb begin
    state_next = state;
    cnt_next   = (cnt != CNT_ZERO) ? cnt - CNT_ONE : cnt;
    rs_next    = lcd_rs;
    d_next     = lcd_d;
    done_next  = 1'b0;
    case (state)
      SB_IDLE: begin
        if (start) begin
          state_next = SB_SETUP;
          cnt_next   = LD_SETUP;
          rs_next    = rs;
          d_next     = nibble;
        end else begin
          rs_next = 1'b0;
          d_next  = 4'h0;
        end
      end
      SB_SETUP: begin
        if (cnt == CNT_ZERO) begin
          state_next = SB_EHIGH;
          cnt_next   = LD_EPULSE;
        end else begin
          state_next = SB_SETUP;
        end
      end
      SB_EHIGH: begin
        if (cnt == CNT_ZERO) begin
          state_next = SB_HOLD;
          cnt_next   = LD_HOLD;
        end else begin
          state_next = SB_EHIGH;
        end
      end
      SB_HOLD: begin
        if (cnt == CNT_ZERO) begin
          state_next = SB_IDLE;
          rs_next    = 1'b0;
          d_next     = 4'h0;
          done_next  = 1'b1;
        end else begin
          state_next = SB_HOLD;
        end
      end
      default: begin
        state_next = SB_IDLE;
        rs_next    = 1'b0;
        d_next     = 4'h0;
      end
    endcase
  end

  // State, counter and registered pin outputs; E follows the next state so it is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SB_IDLE;
      cnt    <= CNT_ZERO;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_d  <= 4'h0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      lcd_e  <= (state_next == SB_EHIGH);
      lcd_rs <= rs_next;
      lcd_d  <= d_next;
      done   <= done_next;
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit write-only driver. Runs the power-on init (wait, four wake-up
// nibbles, four config bytes), then accepts one byte per valid/ready handshake.
// Timing from the accept edge: the FSM stays out of IDLE for
// 2*(T_SETUP+T_EPULSE+T_HOLD) + T_1US + Twait + 4 cycles (one start and one
// done cycle per nibble), and wr_ready is high again on the following cycle.
// The gap with E low between two automatic strobes is
// T_HOLD + 1 + wait + 1 + T_SETUP. After reset PWR_WAIT spends one extra
// cycle loading its counter, so E stays low T_POWERUP + T_SETUP + 2 cycles.
module lcd_char_writer
  import lcd_char_writer_pkg::*;
#(
  parameter int T_POWERUP = T_POWERUP_DEF,
  parameter int T_4100US  = T_4100US_DEF,
  parameter int T_100US   = T_100US_DEF,
  parameter int T_40US    = T_40US_DEF,
  parameter int T_1640US  = T_1640US_DEF,
  parameter int T_1US     = T_1US_DEF,
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_EPULSE  = T_EPULSE_DEF,
  parameter int T_HOLD    = T_HOLD_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_is_cmd,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 32'd1);
  localparam logic [CNT_W-1:0] LD_4100    = CNT_W'(T_4100US - 32'd1);
  localparam logic [CNT_W-1:0] LD_100     = CNT_W'(T_100US - 32'd1);
  localparam logic [CNT_W-1:0] LD_40      = CNT_W'(T_40US - 32'd1);
  localparam logic [CNT_W-1:0] LD_1640    = CNT_W'(T_1640US - 32'd1);
  localparam logic [CNT_W-1:0] LD_1US     = CNT_W'(T_1US - 32'd1);

  wr_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       step, step_next;
  logic             armed, armed_next;
  logic [7:0]       cur_byte, cur_byte_next;
  logic             cur_cmd, cur_cmd_next;
  logic             start, start_next;
  logic [3:0]       nibble, nibble_next;
  logic             nibble_rs, nibble_rs_next;
  logic             init_done_next;
  logic [1:0]       next_step;
  logic [7:0]       cfg_next;
  logic [CNT_W-1:0] init_wait_load;
  logic             strobe_done;

  assign next_step = step + 2'd1;
  assign cfg_next  = cfg_byte(next_step);
  assign lcd_rw    = 1'b0;

  // Wait after each wake-up nibble: 4.1 ms, 100 us, then 40 us twice
  always_comb begin
    case (step)
      2'd0:    init_wait_load = LD_4100;
      2'd1:    init_wait_load = LD_100;
      default: init_wait_load = LD_40;
    endcase
  end

  // Sequencing of init, handshake and byte writes; strobes start on state entry
  always_comb begin
    state_next     = state;
    cnt_next       = (cnt != CNT_ZERO) ? cnt - CNT_ONE : cnt;
    step_next      = step;
    armed_next     = armed;
    cur_byte_next  = cur_byte;
    cur_cmd_next   = cur_cmd;
    start_next     = 1'b0;
    nibble_next    = nibble;
    nibble_rs_next = nibble_rs;
    init_done_next = init_done;
    case (state)
      ST_PWR_WAIT: begin
        if (!armed) begin
          armed_next = 1'b1;
          cnt_next   = LD_POWERUP;
        end else if (cnt == CNT_ZERO) begin
          state_next     = ST_INIT_NIB;
          start_next     = 1'b1;
          nibble_next    = init_nibble(step);
          nibble_rs_next = 1'b0;
        end else begin
          state_next = ST_PWR_WAIT;
        end
      end
      ST_INIT_NIB: begin
        if (strobe_done) begin
          state_next = ST_INIT_WAIT;
          cnt_next   = init_wait_load;
        end else begin
          state_next = ST_INIT_NIB;
        end
      end
      ST_INIT_WAIT: begin
        if (cnt == CNT_ZERO) begin
          step_next      = next_step;
          start_next     = 1'b1;
          nibble_rs_next = 1'b0;
          if (step == 2'd3) begin
            state_next    = ST_WR_HI;
            cur_byte_next = cfg_next;
            cur_cmd_next  = 1'b1;
            nibble_next   = cfg_next[7:4];
          end else begin
            state_next  = ST_INIT_NIB;
            nibble_next = init_nibble(next_step);
          end
        end else begin
          state_next = ST_INIT_WAIT;
        end
      end
      ST_IDLE: begin
        if (wr_valid && wr_ready) begin
          state_next     = ST_WR_HI;
          cur_byte_next  = wr_data;
          cur_cmd_next   = wr_is_cmd;
          start_next     = 1'b1;
          nibble_next    = wr_data[7:4];
          nibble_rs_next = !wr_is_cmd;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WR_HI: begin
        if (strobe_done) begin
          state_next = ST_WR_GAP;
          cnt_next   = LD_1US;
        end else begin
          state_next = ST_WR_HI;
        end
      end
      ST_WR_GAP: begin
        if (cnt == CNT_ZERO) begin
          state_next     = ST_WR_LO;
          start_next     = 1'b1;
          nibble_next    = cur_byte[3:0];
          nibble_rs_next = !cur_cmd;
        end else begin
          state_next = ST_WR_GAP;
        end
      end
      ST_WR_LO: begin
        if (strobe_done) begin
          state_next = ST_WAIT;
          cnt_next   = needs_long_wait(cur_cmd, cur_byte) ? LD_1640 : LD_40;
        end else begin
          state_next = ST_WR_LO;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_ZERO) begin
          if (init_done) begin
            state_next = ST_IDLE;
          end else if (step == 2'd3) begin
            state_next     = ST_IDLE;
            init_done_next = 1'b1;
          end else begin
            state_next     = ST_WR_HI;
            step_next      = next_step;
            cur_byte_next  = cfg_next;
            cur_cmd_next   = 1'b1;
            start_next     = 1'b1;
            nibble_next    = cfg_next[7:4];
            nibble_rs_next = 1'b0;
          end
        end else begin
          state_next = ST_WAIT;
        end
      end
      default: begin
        state_next = ST_PWR_WAIT;
        armed_next = 1'b0;
      end
    endcase
  end

  // FSM registers; wr_ready is registered and high exactly while in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PWR_WAIT;
      cnt       <= CNT_ZERO;
      step      <= 2'd0;
      armed     <= 1'b0;
      cur_byte  <= 8'h00;
      cur_cmd   <= 1'b0;
      start     <= 1'b0;
      nibble    <= 4'h0;
      nibble_rs <= 1'b0;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      step      <= step_next;
      armed     <= armed_next;
      cur_byte  <= cur_byte_next;
      cur_cmd   <= cur_cmd_next;
      start     <= start_next;
      nibble    <= nibble_next;
      nibble_rs <= nibble_rs_next;
      init_done <= init_done_next;
      wr_ready  <= (state_next == ST_IDLE);
    end
  end

  lcd_nibble_strobe #(
    .CNT_W    (CNT_W),
    .T_SETUP  (T_SETUP),
    .T_EPULSE (T_EPULSE),
    .T_HOLD   (T_HOLD)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rs     (nibble_rs),
    .nibble (nibble),
    .lcd_e  (lcd_e),
    .lcd_rs (lcd_rs),
    .lcd_d  (lcd_d),
    .done   (strobe_done)
  );

endmodule
